// File: rtl/bf16_pkg.sv
// Shared BF16 field widths, special encodings and accumulator FSM states.
package bf16_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 7;
    localparam int unsigned BIAS  = 127;

    localparam logic [15:0] QNAN       = 16'h7FC0;
    localparam logic [15:0] POS_INF    = 16'h7F80;
    localparam logic [15:0] MAX_FINITE = 16'h7F7F;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm
    } state_e;

endpackage

// File: rtl/bf16_lzc.sv
// Leading-zero counter used to normalise the adder result in one cycle.
module bf16_lzc #(
    parameter int unsigned W  = 11,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count
);

    // Ascending scan: the highest set bit is the last one to assign.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (i_data[i]) o_count = CW'(int'(W) - 1 - i);
        end
    end

endmodule

// File: rtl/bf16_acc.sv
// Sequential BF16 dot-product accumulator: align/add/normalise/round FSM, one term per 4 cycles.
// Define BF16_ACC_SAT_EN to saturate overflow to the largest finite value instead of infinity.
module bf16_acc
    import bf16_pkg::*;
#(
    parameter int unsigned GRS_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_exc,
    input  logic             in_last,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow,
    output logic             underflow,
    output logic             exception
);

    localparam int unsigned SIG_W = 1 + MAN_W + GRS_W;
    localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
    localparam int unsigned E2    = EXP_W + 2;

    state_e             r_state;
    logic [15:0]        r_acc, r_op;
    logic               r_last, r_exc, r_clr_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign, r_sub, r_nan;
    logic [EXP_W-1:0]   r_exp;
    logic [SIG_W-1:0]   r_big, r_small;
    logic [SIG_W:0]     r_sum;
    logic               r_out_valid;
    logic [15:0]        r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_ovf, r_unf, r_excf;

    // ---------------- align ----------------
    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_big, w_diff;
    logic [14:0]      w_mag_a, w_mag_b;
    logic [SIG_W-1:0] w_sig_a, w_sig_b, w_big, w_small, w_mask, w_shifted, w_small_al;
    logic             w_swap, w_nan;

    assign w_exp_a = r_acc[14:7];
    assign w_exp_b = r_op[14:7];
    assign w_mag_a = (w_exp_a == '0) ? '0 : r_acc[14:0];
    assign w_mag_b = (w_exp_b == '0) ? '0 : r_op[14:0];
    assign w_sig_a = (w_exp_a == '0) ? '0 : {1'b1, r_acc[MAN_W-1:0], {GRS_W{1'b0}}};
    assign w_sig_b = (w_exp_b == '0) ? '0 : {1'b1, r_op[MAN_W-1:0], {GRS_W{1'b0}}};
    assign w_swap    = (w_mag_b > w_mag_a);
    assign w_big     = w_swap ? w_sig_b : w_sig_a;
    assign w_small   = w_swap ? w_sig_a : w_sig_b;
    assign w_exp_big = w_swap ? w_exp_b : w_exp_a;
    assign w_diff    = w_swap ? (w_exp_b - w_exp_a) : (w_exp_a - w_exp_b);
    assign w_mask    = (w_diff >= EXP_W'(SIG_W)) ? '1 : ((SIG_W'(1) << w_diff) - SIG_W'(1));
    assign w_shifted = w_small >> w_diff;
    // Everything shifted out below the last GRS bit collapses into sticky.
    assign w_small_al = {w_shifted[SIG_W-1:1], w_shifted[0] | (|(w_small & w_mask))};
    assign w_nan = r_exc || (w_exp_a == '1) || (w_exp_b == '1);

    // ---------------- normalise / round ----------------
    logic [LZ_W-1:0]  w_lz;
    logic [SIG_W-1:0] w_norm;
    logic [E2-1:0]    w_exp_n, w_exp_f;
    logic             w_rup, w_zero;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_man_f;
    logic [15:0]      w_res;
    logic             w_set_ovf, w_set_unf, w_set_exc;
    logic [CNT_W-1:0] w_cnt_inc;

    bf16_lzc #(
        .W  (SIG_W),
        .CW (LZ_W)
    ) u_lzc (
        .i_data  (r_sum[SIG_W-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r_sum[SIG_W]) begin
            w_norm  = {r_sum[SIG_W:2], r_sum[1] | r_sum[0]};
            w_exp_n = E2'(r_exp) + E2'(1);
        end else begin
            w_norm  = r_sum[SIG_W-1:0] << w_lz;
            w_exp_n = E2'(r_exp) - E2'(w_lz);
        end
    end

    assign w_zero  = (r_sum == '0);
    assign w_rup   = w_norm[GRS_W-1] & ((|w_norm[GRS_W-2:0]) | w_norm[GRS_W]);
    assign w_rnd   = {1'b0, w_norm[SIG_W-1:GRS_W]} + (MAN_W + 2)'(w_rup);
    assign w_exp_f = w_exp_n + E2'(w_rnd[MAN_W+1]);
    assign w_man_f = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_res     = {r_sign, w_exp_f[EXP_W-1:0], w_man_f};
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_set_exc = 1'b0;
        if (r_nan) begin
            w_res     = QNAN;
            w_set_exc = 1'b1;
        end else if (w_zero) begin
            w_res = '0;
        end else if (!w_exp_f[E2-1] && (w_exp_f >= E2'({EXP_W{1'b1}}))) begin
            w_set_ovf = 1'b1;
`ifdef BF16_ACC_SAT_EN
            w_res = {r_sign, MAX_FINITE[14:0]};
`else
            w_res = {r_sign, POS_INF[14:0]};
`endif
        end else if (w_exp_f[E2-1] || (w_exp_f == '0)) begin
            w_set_unf = 1'b1;
            w_res     = {r_sign, 15'b0};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_op        <= '0;
            r_last      <= 1'b0;
            r_exc       <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_nan       <= 1'b0;
            r_exp       <= '0;
            r_big       <= '0;
            r_small     <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_excf      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (clear && (r_state != StIdle)) r_clr_pend <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    // Flags stay visible alongside out_valid, then drop.
                    if (r_out_valid) begin
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_excf <= 1'b0;
                    end
                    if (clear) begin
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_excf <= 1'b0;
                    end else if (in_valid) begin
                        r_op       <= in_data;
                        r_last     <= in_last;
                        r_exc      <= in_exc;
                        r_clr_pend <= 1'b0;
                        r_state    <= StAlign;
                    end
                end
                StAlign: begin
                    r_big   <= w_big;
                    r_small <= w_small_al;
                    r_exp   <= w_exp_big;
                    r_sign  <= w_swap ? r_op[15] : r_acc[15];
                    r_sub   <= r_op[15] ^ r_acc[15];
                    r_nan   <= w_nan;
                    r_state <= StAdd;
                end
                StAdd: begin
                    r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                     : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= StNorm;
                end
                StNorm: begin
                    r_state    <= StIdle;
                    r_clr_pend <= 1'b0;
                    if (clear || r_clr_pend) begin
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_excf <= 1'b0;
                    end else begin
                        r_ovf  <= r_ovf | w_set_ovf;
                        r_unf  <= r_unf | w_set_unf;
                        r_excf <= r_excf | w_set_exc;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                            r_out_count <= w_cnt_inc;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                        end else begin
                            r_acc <= w_res;
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle) && !clear;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign exception = r_excf;

endmodule

// File: tb/tb_bf16_acc.sv
// Scoreboard bench for bf16_acc: directed dot products, expected sums queued at issue time.
module tb_bf16_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_exc = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        overflow, underflow, exception;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  cnt;
        logic [2:0]  flags; // {overflow, underflow, exception}
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    bf16_acc dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exc    (in_exc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [15:0] d, input logic [7:0] c, input logic [2:0] f);
        exp_t x;
        x.data = d;
        x.cnt = c;
        x.flags = f;
        sb.push_back(x);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=0, required 1 within 100 cycles");
        end
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [15:0] d, input logic exc, input logic last);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_exc   = exc;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_exc   = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got out_data %h, required no output", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_count", 32'(out_count), 32'(e.cnt));
                check("out_flags", 32'({overflow, underflow, exception}), 32'(e.flags));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_flags", 32'({overflow, underflow, exception}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sum with latency check
        send(16'h3F80, 1'b0, 1'b0);
        expect_out(16'h4040, 8'd2, 3'b000);
        send(16'h4000, 1'b0, 1'b1);
        check("ready_drop", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 check("lat_t2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_t3", 32'(out_valid), 32'd1);

        // Cancellation
        send(16'h3F80, 1'b0, 1'b0);
        expect_out(16'h0000, 8'd2, 3'b000);
        send(16'hBF80, 1'b0, 1'b1);

        // Round to nearest even: tie stays, tie on odd rounds up
        send(16'h3F80, 1'b0, 1'b0);
        expect_out(16'h3F80, 8'd2, 3'b000);
        send(16'h3B80, 1'b0, 1'b1);
        send(16'h3F81, 1'b0, 1'b0);
        expect_out(16'h3F82, 8'd2, 3'b000);
        send(16'h3B80, 1'b0, 1'b1);

        // Overflow
        send(16'h7F00, 1'b0, 1'b0);
`ifdef BF16_ACC_SAT_EN
        expect_out(16'h7F7F, 8'd2, 3'b100);
`else
        expect_out(16'h7F80, 8'd2, 3'b100);
`endif
        send(16'h7F00, 1'b0, 1'b1);

        // Underflow: 2^-125 minus just under it leaves 2^-133
        send(16'h0100, 1'b0, 1'b0);
        expect_out(16'h0000, 8'd2, 3'b010);
        send(16'h80FF, 1'b0, 1'b1);

        // Exception then recovery
        send(16'h3F80, 1'b1, 1'b0);
        expect_out(16'h7FC0, 8'd2, 3'b001);
        send(16'h4000, 1'b0, 1'b1);
        expect_out(16'h4000, 8'd1, 3'b000);
        send(16'h4000, 1'b0, 1'b1);

        // Clear in IDLE blocks a same-cycle term and zeroes acc/counter
        send(16'h4000, 1'b0, 1'b0);
        @(negedge clk);
        wait_ready();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        #1 check("clear_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_out(16'h3F80, 8'd1, 3'b000);
        send(16'h3F80, 1'b0, 1'b1);

        // Reset during ADD abandons the term and zeroes acc
        send(16'h3F80, 1'b0, 1'b0);
        send(16'h4000, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        expect_out(16'h4040, 8'd1, 3'b000);
        send(16'h4040, 1'b0, 1'b1);

        // Term counter saturates at 255
        expect_out(16'h0000, 8'd255, 3'b000);
        for (int i = 0; i < 256; i++) send(16'h0000, 1'b0, (i == 255));

        // Drain
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
